// File: rtl/ir_pkg.sv
// Shared types and constants for the NEC IR key decoder.
package ir_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } irState_e;

  // Bit offsets of the four NEC bytes inside the raw receiver word.
  localparam int ByteAddrLsb    = 24;
  localparam int ByteAddrInvLsb = 16;
  localparam int ByteCmdLsb     = 8;
  localparam int ByteCmdInvLsb  = 0;

  localparam int DefTimeout  = 5_500_000;
  localparam int DefHoldRpts = 4;
  localparam int TmoW        = 23;

  function automatic logic [7:0] revByte(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/nec_frame_check.sv
// Combinational NEC frame check: optional per-byte bit reversal, complement
// check and address extraction.
module nec_frame_check
  import ir_pkg::*;
#(
  parameter bit BIT_REV     = 1'b1,
  parameter bit EXT_ADDR_EN = 1'b0
) (
  input  logic [31:0] i_frame,
  output logic        o_valid,
  output logic [7:0]  o_cmd,
  output logic [15:0] o_addr
);

  logic [7:0] raw0, raw1, raw2, raw3;
  logic [7:0] byte0, byte1, byte2, byte3;

  assign raw0 = i_frame[ByteAddrLsb    +: 8];
  assign raw1 = i_frame[ByteAddrInvLsb +: 8];
  assign raw2 = i_frame[ByteCmdLsb     +: 8];
  assign raw3 = i_frame[ByteCmdInvLsb  +: 8];

  // The receiver packs the first (LSB) bit on air into the MSB of each byte.
  assign byte0 = BIT_REV ? revByte(raw0) : raw0;
  assign byte1 = BIT_REV ? revByte(raw1) : raw1;
  assign byte2 = BIT_REV ? revByte(raw2) : raw2;
  assign byte3 = BIT_REV ? revByte(raw3) : raw3;

  assign o_valid = (byte3 == ~byte2) && (EXT_ADDR_EN || (byte1 == ~byte0));
  assign o_cmd   = byte2;
  assign o_addr  = EXT_ADDR_EN ? {byte1, byte0} : {8'h00, byte0};

endmodule

// File: rtl/ir_key_decoder.sv
// IR key decoder: turns NEC frames and repeat strobes into press, auto-repeat,
// release and error events with registered 1-cycle strobes.
module ir_key_decoder
  import ir_pkg::*;
#(
  parameter bit          BIT_REV      = 1'b1,
  parameter bit          EXT_ADDR_EN  = 1'b0,
  parameter bit          ADDR_FILT_EN = 1'b0,
  parameter logic [15:0] ADDR_MATCH   = 16'h0000,
  parameter int          TIMEOUT      = DefTimeout,
  parameter int          HOLD_RPTS    = DefHoldRpts
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_frame,
  input  logic        i_frame_vld,
  input  logic        i_repeat,
  output logic [7:0]  o_key,
  output logic [15:0] o_addr,
  output logic        o_key_vld,
  output logic        o_key_rpt,
  output logic        o_held,
  output logic        o_release,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  localparam int              RptW    = (HOLD_RPTS < 1) ? 1 : $clog2(HOLD_RPTS + 1);
  localparam logic [RptW-1:0] RptMax  = RptW'(HOLD_RPTS);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  logic        chkValid;
  logic [7:0]  chkCmd;
  logic [15:0] chkAddr;
  logic        addrOk;
  logic        acceptFrame;

  irState_e        state_q;
  logic [TmoW-1:0] tmo_q;
  logic [RptW-1:0] rptCnt_q;
  logic [7:0]      key_q;
  logic [15:0]     addr_q;
  logic            keyVld_q;
  logic            keyRpt_q;
  logic            held_q;
  logic            release_q;
  logic            err_q;
  logic [7:0]      errCnt_q;

  nec_frame_check #(
    .BIT_REV     (BIT_REV),
    .EXT_ADDR_EN (EXT_ADDR_EN)
  ) u_check (
    .i_frame (i_frame),
    .o_valid (chkValid),
    .o_cmd   (chkCmd),
    .o_addr  (chkAddr)
  );

  // Non-extended mode only carries an 8-bit address, so only the low byte is matched.
  assign addrOk = !ADDR_FILT_EN ||
                  (EXT_ADDR_EN ? (chkAddr == ADDR_MATCH) : (chkAddr[7:0] == ADDR_MATCH[7:0]));
  assign acceptFrame = i_frame_vld && chkValid && addrOk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      rptCnt_q  <= '0;
      key_q     <= '0;
      addr_q    <= '0;
      keyVld_q  <= 1'b0;
      keyRpt_q  <= 1'b0;
      held_q    <= 1'b0;
      release_q <= 1'b0;
      err_q     <= 1'b0;
      errCnt_q  <= '0;
    end else begin
      keyVld_q  <= 1'b0;
      keyRpt_q  <= 1'b0;
      release_q <= 1'b0;
      err_q     <= 1'b0;

      if (i_frame_vld && !chkValid) begin
        err_q <= 1'b1;
        if (errCnt_q != 8'hFF) errCnt_q <= errCnt_q + 8'd1;
      end

      if (acceptFrame) begin
        key_q    <= chkCmd;
        addr_q   <= chkAddr;
        keyVld_q <= 1'b1;
        held_q   <= 1'b1;
        rptCnt_q <= '0;
        tmo_q    <= '0;
        state_q  <= HELD;
      end else if (state_q == HELD) begin
        // A repeat sharing its cycle with any frame strobe is discarded.
        if (i_repeat && !i_frame_vld) begin
          tmo_q <= '0;
          if (rptCnt_q < RptMax) begin
            rptCnt_q <= rptCnt_q + 1'b1;
          end else begin
            keyVld_q <= 1'b1;
            keyRpt_q <= 1'b1;
          end
        end else if (tmo_q == TmoLast) begin
          release_q <= 1'b1;
          held_q    <= 1'b0;
          state_q   <= IDLE;
        end else begin
          tmo_q <= tmo_q + 1'b1;
        end
      end
    end
  end

  assign o_key     = key_q;
  assign o_addr    = addr_q;
  assign o_key_vld = keyVld_q;
  assign o_key_rpt = keyRpt_q;
  assign o_held    = held_q;
  assign o_release = release_q;
  assign o_err     = err_q;
  assign o_err_cnt = errCnt_q;

endmodule

// File: tb/tb_ir_key_decoder.sv
// Self-checking bench for ir_key_decoder: directed scenarios plus a randomized
// run against a behavioural key-event model.
module tb_ir_key_decoder;

  localparam int Timeout  = 1000;
  localparam int HoldRpts = 2;

  localparam logic [31:0] FramePress = 32'h00FF_A25D;
  localparam logic [31:0] FrameBad   = 32'h00FF_A25C;
  localparam logic [31:0] Frame46    = 32'h00FF_629D;
  localparam logic [31:0] FrameAddr4 = 32'h20DF_A25D;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_frame;
  logic        i_frame_vld;
  logic        i_repeat;

  logic [7:0]  dKey,    fKey;
  logic [15:0] dAddr,   fAddr;
  logic        dKeyVld, fKeyVld;
  logic        dKeyRpt, fKeyRpt;
  logic        dHeld,   fHeld;
  logic        dRel,    fRel;
  logic        dErr,    fErr;
  logic [7:0]  dErrCnt, fErrCnt;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  ir_key_decoder #(
    .BIT_REV      (1'b1),
    .EXT_ADDR_EN  (1'b0),
    .ADDR_FILT_EN (1'b0),
    .ADDR_MATCH   (16'h0000),
    .TIMEOUT      (Timeout),
    .HOLD_RPTS    (HoldRpts)
  ) dut (
    .clk (clk), .rst_n (rst_n), .i_frame (i_frame), .i_frame_vld (i_frame_vld),
    .i_repeat (i_repeat), .o_key (dKey), .o_addr (dAddr), .o_key_vld (dKeyVld),
    .o_key_rpt (dKeyRpt), .o_held (dHeld), .o_release (dRel), .o_err (dErr),
    .o_err_cnt (dErrCnt)
  );

  ir_key_decoder #(
    .BIT_REV      (1'b1),
    .EXT_ADDR_EN  (1'b0),
    .ADDR_FILT_EN (1'b1),
    .ADDR_MATCH   (16'h0004),
    .TIMEOUT      (Timeout),
    .HOLD_RPTS    (HoldRpts)
  ) dutFilt (
    .clk (clk), .rst_n (rst_n), .i_frame (i_frame), .i_frame_vld (i_frame_vld),
    .i_repeat (i_repeat), .o_key (fKey), .o_addr (fAddr), .o_key_vld (fKeyVld),
    .o_key_rpt (fKeyRpt), .o_held (fHeld), .o_release (fRel), .o_err (fErr),
    .o_err_cnt (fErrCnt)
  );

  function automatic logic [7:0] bitRev(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = b[i];
    return r;
  endfunction

  // Builds the word the receiver would deliver for an on-air NEC frame.
  function automatic logic [31:0] makeFrame(input logic [7:0] addr, input logic [7:0] cmd);
    return {bitRev(addr), bitRev(~addr), bitRev(cmd), bitRev(~cmd)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    i_frame     = '0;
    i_frame_vld = 1'b0;
    i_repeat    = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({dKey, dAddr, dKeyVld, dKeyRpt, dHeld, dRel, dErr, dErrCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got key=%h addr=%h vld=%b rpt=%b held=%b rel=%b err=%b cnt=%0d, expected all 0",
               dKey, dAddr, dKeyVld, dKeyRpt, dHeld, dRel, dErr, dErrCnt);
    end
  endtask

  task automatic test_press();
    doReset();
    i_frame = FramePress; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    checks++;
    if ({dKeyVld, dKeyRpt, dKey, dAddr, dHeld} !== {1'b1, 1'b0, 8'h45, 16'h0000, 1'b1}) begin
      errors++;
      $display("[TB] FAIL press_event: got vld=%b rpt=%b key=%h addr=%h held=%b, expected 1 0 45 0000 1",
               dKeyVld, dKeyRpt, dKey, dAddr, dHeld);
    end
    step();
    checks++;
    if ({dKeyVld, dHeld} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL press_one_cycle: got vld=%b held=%b, expected 0 1", dKeyVld, dHeld);
    end
  endtask

  task automatic test_hold();
    bit sawBad = 1'b0;
    bit relEarly = 1'b0;
    doReset();
    i_frame = FramePress; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    for (int r = 1; r <= 4; r++) begin
      repeat (499) begin
        step();
        sawBad |= dKeyVld | dRel;
      end
      i_repeat = 1'b1;
      step();
      i_repeat = 1'b0;
      checks++;
      if ({dKeyVld, dKeyRpt, dKey, dHeld} !== {(r > HoldRpts), (r > HoldRpts), 8'h45, 1'b1}) begin
        errors++;
        $display("[TB] FAIL hold_repeat_%0d: got vld=%b rpt=%b key=%h held=%b, expected vld=rpt=%b key=45 held=1",
                 r, dKeyVld, dKeyRpt, dKey, dHeld, (r > HoldRpts));
      end
    end
    checks++;
    if (sawBad) begin
      errors++;
      $display("[TB] FAIL hold_gaps: got spurious key/release between repeats, expected none");
    end
    repeat (Timeout - 1) begin
      step();
      relEarly |= dRel | dKeyVld;
    end
    checks++;
    if (relEarly || !dHeld) begin
      errors++;
      $display("[TB] FAIL hold_no_early_release: got early=%b held=%b, expected 0 1", relEarly, dHeld);
    end
    step();
    checks++;
    if ({dRel, dHeld, dKey} !== {1'b1, 1'b0, 8'h45}) begin
      errors++;
      $display("[TB] FAIL hold_release: got rel=%b held=%b key=%h, expected 1 0 45", dRel, dHeld, dKey);
    end
    step();
    checks++;
    if (dRel !== 1'b0) begin
      errors++;
      $display("[TB] FAIL release_one_cycle: got rel=%b, expected 0", dRel);
    end
  endtask

  task automatic test_error();
    doReset();
    i_frame = FrameBad; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    checks++;
    if ({dErr, dErrCnt, dKeyVld, dHeld} !== {1'b1, 8'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL error_idle: got err=%b cnt=%0d vld=%b held=%b, expected 1 1 0 0", dErr, dErrCnt, dKeyVld, dHeld);
    end
    i_frame = FramePress; i_frame_vld = 1'b1;
    step();
    i_frame = FrameBad;
    step();
    i_frame_vld = 1'b0;
    checks++;
    if ({dErr, dErrCnt, dKeyVld, dHeld, dKey} !== {1'b1, 8'd2, 1'b0, 1'b1, 8'h45}) begin
      errors++;
      $display("[TB] FAIL error_held: got err=%b cnt=%0d vld=%b held=%b key=%h, expected 1 2 0 1 45",
               dErr, dErrCnt, dKeyVld, dHeld, dKey);
    end
    i_frame_vld = 1'b1;
    repeat (300) step();
    i_frame_vld = 1'b0;
    checks++;
    if ({dErr, dErrCnt, dHeld} !== {1'b1, 8'd255, 1'b1}) begin
      errors++;
      $display("[TB] FAIL error_saturate: got err=%b cnt=%0d held=%b, expected 1 255 1", dErr, dErrCnt, dHeld);
    end
    step();
    checks++;
    if ({dErr, dErrCnt} !== {1'b0, 8'd255}) begin
      errors++;
      $display("[TB] FAIL error_hold_count: got err=%b cnt=%0d, expected 0 255", dErr, dErrCnt);
    end
  endtask

  task automatic test_repress();
    bit sawRel = 1'b0;
    doReset();
    i_frame = FramePress; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    repeat (3) begin
      repeat (20) step();
      i_repeat = 1'b1;
      step();
      i_repeat = 1'b0;
    end
    i_frame = Frame46; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    checks++;
    if ({dKeyVld, dKeyRpt, dKey, dRel, dHeld} !== {1'b1, 1'b0, 8'h46, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL repress_event: got vld=%b rpt=%b key=%h rel=%b held=%b, expected 1 0 46 0 1",
               dKeyVld, dKeyRpt, dKey, dRel, dHeld);
    end
    for (int r = 1; r <= 3; r++) begin
      repeat (10) begin
        step();
        sawRel |= dRel;
      end
      i_repeat = 1'b1;
      step();
      i_repeat = 1'b0;
      checks++;
      if ({dKeyVld, dKeyRpt, dKey} !== {(r > HoldRpts), (r > HoldRpts), 8'h46}) begin
        errors++;
        $display("[TB] FAIL repress_repeat_%0d: got vld=%b rpt=%b key=%h, expected vld=rpt=%b key=46",
                 r, dKeyVld, dKeyRpt, dKey, (r > HoldRpts));
      end
    end
    checks++;
    if (sawRel) begin
      errors++;
      $display("[TB] FAIL repress_no_release: got a release strobe, expected none");
    end
  endtask

  task automatic test_corner();
    bit sawRel = 1'b0;
    doReset();
    i_repeat = 1'b1;
    step();
    i_repeat = 1'b0;
    checks++;
    if ({dKeyVld, dHeld, dRel, dErr} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL repeat_in_idle: got vld=%b held=%b rel=%b err=%b, expected 0 0 0 0", dKeyVld, dHeld, dRel, dErr);
    end
    i_frame = FramePress; i_frame_vld = 1'b1; i_repeat = 1'b1;
    step();
    i_frame_vld = 1'b0; i_repeat = 1'b0;
    checks++;
    if ({dKeyVld, dKeyRpt, dKey, dHeld} !== {1'b1, 1'b0, 8'h45, 1'b1}) begin
      errors++;
      $display("[TB] FAIL frame_and_repeat: got vld=%b rpt=%b key=%h held=%b, expected 1 0 45 1", dKeyVld, dKeyRpt, dKey, dHeld);
    end
    // Saturate the repeat count, then collide a frame with a repeat while held.
    repeat (2) begin
      i_repeat = 1'b1; step(); i_repeat = 1'b0; step();
    end
    i_frame_vld = 1'b1; i_repeat = 1'b1;
    step();
    i_frame_vld = 1'b0; i_repeat = 1'b0;
    checks++;
    if ({dKeyVld, dKeyRpt} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL frame_and_repeat_held: got vld=%b rpt=%b, expected 1 0", dKeyVld, dKeyRpt);
    end
    repeat (Timeout - 1) step();
    i_repeat = 1'b1;
    step();
    i_repeat = 1'b0;
    checks++;
    if ({dRel, dHeld, dKeyVld} !== 3'b010) begin
      errors++;
      $display("[TB] FAIL repeat_at_expiry: got rel=%b held=%b vld=%b, expected 0 1 0", dRel, dHeld, dKeyVld);
    end
    repeat (10) step();
    #5 rst_n = 1'b0;
    #1;
    checks++;
    if ({dKey, dAddr, dKeyVld, dKeyRpt, dHeld, dRel, dErr, dErrCnt} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold: got key=%h held=%b rel=%b, expected all outputs 0", dKey, dHeld, dRel);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (Timeout + 100) begin
      step();
      sawRel |= dRel | dHeld;
    end
    checks++;
    if (sawRel) begin
      errors++;
      $display("[TB] FAIL reset_no_release: got release/held after reset, expected none");
    end
  endtask

  task automatic test_filter();
    doReset();
    i_frame = FramePress; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    checks++;
    if ({fKeyVld, fHeld, fErr} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL filter_drop: got vld=%b held=%b err=%b, expected 0 0 0", fKeyVld, fHeld, fErr);
    end
    i_frame = FrameAddr4; i_frame_vld = 1'b1;
    step();
    i_frame_vld = 1'b0;
    checks++;
    if ({fKeyVld, fKeyRpt, fKey, fAddr, fHeld} !== {1'b1, 1'b0, 8'h45, 16'h0004, 1'b1}) begin
      errors++;
      $display("[TB] FAIL filter_pass: got vld=%b rpt=%b key=%h addr=%h held=%b, expected 1 0 45 0004 1",
               fKeyVld, fKeyRpt, fKey, fAddr, fHeld);
    end
  endtask

  // Randomized traffic checked cycle by cycle against a key-event model that
  // tracks "is a key down", repeats seen since the press and quiet cycles.
  task automatic test_random();
    bit          held = 1'b0;
    int          reps = 0;
    int          quiet = 0;
    int          errCnt = 0;
    logic [7:0]  eKey = '0;
    logic [15:0] eAddr = '0;
    doReset();
    for (int c = 0; c < 24000; c++) begin
      int unsigned span = ((c / 1500) % 2 == 1) ? 20000 : 1000;
      int unsigned r    = $urandom_range(0, span - 1);
      logic [31:0] f    = $urandom;
      bit          fv   = 1'b0;
      bit          rp   = 1'b0;
      bit          fresh = 1'b0;
      bit          eVld = 1'b0, eRpt = 1'b0, eRel = 1'b0, eErr = 1'b0;
      logic [7:0]  a, ai, k, ki;
      if (r < 4)        begin fv = 1'b1; f = makeFrame(8'($urandom), 8'($urandom)); end
      else if (r < 6)   fv = 1'b1;
      else if (r < 14)  rp = 1'b1;
      else if (r == 14) begin fv = 1'b1; rp = 1'b1; f = makeFrame(8'($urandom), 8'($urandom)); end
      i_frame = f; i_frame_vld = fv; i_repeat = rp;
      step();
      i_frame_vld = 1'b0; i_repeat = 1'b0;

      a = bitRev(f[31:24]); ai = bitRev(f[23:16]); k = bitRev(f[15:8]); ki = bitRev(f[7:0]);
      if (fv) begin
        if ((k ^ ki) == 8'hFF && (a ^ ai) == 8'hFF) begin
          eKey = k; eAddr = {8'h00, a}; eVld = 1'b1;
          held = 1'b1; reps = 0; quiet = 0; fresh = 1'b1;
        end else begin
          eErr = 1'b1;
          if (errCnt < 255) errCnt++;
        end
      end else if (rp && held) begin
        quiet = 0; fresh = 1'b1;
        if (reps < HoldRpts) reps++;
        else begin eVld = 1'b1; eRpt = 1'b1; end
      end
      if (held && !fresh) begin
        quiet++;
        if (quiet == Timeout) begin eRel = 1'b1; held = 1'b0; end
      end

      checks++;
      if ({dKey, dAddr, dKeyVld, dKeyRpt, dHeld, dRel, dErr, dErrCnt} !==
          {eKey, eAddr, eVld, eRpt, held, eRel, eErr, 8'(errCnt)}) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d: got key=%h addr=%h vld=%b rpt=%b held=%b rel=%b err=%b cnt=%0d, expected key=%h addr=%h vld=%b rpt=%b held=%b rel=%b err=%b cnt=%0d",
                 c, dKey, dAddr, dKeyVld, dKeyRpt, dHeld, dRel, dErr, dErrCnt,
                 eKey, eAddr, eVld, eRpt, held, eRel, eErr, errCnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_hold();
    test_error();
    test_repress();
    test_corner();
    test_filter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
